program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter IM_DEPTH, default 256, meaning the maximum number of 16-bit instruction words that may be loaded.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_valid, input, 1 bit: the upstream byte source holds a byte.
REQ-005 The block SHALL have port rx_data, input, 8 bits: the byte from the upstream source.
REQ-006 The block SHALL have port rx_ready, output, 1 bit: the loader can accept a byte.
REQ-007 The block SHALL have port im_we, output, 1 bit: write strobe to instruction memory.
REQ-008 The block SHALL have port im_addr, output, 16 bits: instruction memory word address.
REQ-009 The block SHALL have port im_wdata, output, 16 bits: instruction word to write.
REQ-010 The block SHALL have port core_rst_n, output, 1 bit: processor core reset, active-low.
REQ-011 The block SHALL have port load_done, output, 1 bit: the image loaded with a valid checksum.
REQ-012 The block SHALL have port load_err, output, 1 bit: the load failed.
REQ-013 The block SHALL have port word_count, output, 16 bits: the number of words written so far.

Function
REQ-014 A byte SHALL be accepted on a rising edge where rx_valid=1 and rx_ready=1; rx_data is sampled at that edge.
REQ-015 The byte stream SHALL be: LEN_HI, LEN_LO, then N words sent high byte first, then one checksum byte.
- N = {LEN_HI, LEN_LO}.
- The checksum SHALL be the XOR of all 2N data bytes.
REQ-016 The FSM SHALL have exactly these states: S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR.
REQ-017 rx_ready SHALL be 1 in S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO and S_CHECK, and 0 in S_DONE and S_ERR.
REQ-018 Transitions SHALL occur only on an accepted byte, except that S_DONE and S_ERR are terminal until reset:
- LEN_HI → LEN_LO.
- LEN_LO → ERR if N > IM_DEPTH; else CHECK if N = 0; else DATA_HI.
- DATA_HI → DATA_LO.
- DATA_LO → CHECK if this is word N; else DATA_HI.
- CHECK → DONE if the byte equals the running XOR; else ERR.
REQ-019 When a DATA_LO byte is accepted, the next cycle SHALL have, for exactly one cycle:
- im_we = 1;
- im_addr = index of the word (0-based);
- im_wdata = {hi byte, lo byte}.
REQ-020 word_count SHALL increment by 1 on the same edge that asserts im_we.
REQ-021 im_addr and im_wdata SHALL hold their last values while im_we = 0.
REQ-022 The running XOR SHALL be 8 bits, cleared at reset, and updated on every accepted data byte; length and checksum bytes SHALL NOT update it.
REQ-023 core_rst_n and load_done SHALL be registered and equal 1 only in S_DONE; load_err SHALL equal 1 only in S_ERR.
REQ-024 A checksum byte accepted while the final im_we pulse is active SHALL be legal; the write SHALL still complete.
REQ-025 Accepted-byte and im_we latency SHALL be fixed: one byte per cycle sustained, with no back-pressure other than S_DONE and S_ERR.
REQ-026 N = IM_DEPTH SHALL be accepted; the last write goes to im_addr = IM_DEPTH-1.

Reset
REQ-027 While rst = 0, all outputs SHALL be as follows:
- state = S_LEN_HI;
- rx_ready = 0;
- im_we = 0, im_addr = 0, im_wdata = 0, word_count = 0;
- core_rst_n = 0, load_done = 0, load_err = 0;
- running XOR = 0.
REQ-028 rx_ready SHALL rise in the first cycle after rst deasserts.
REQ-029 A reset asserted mid-load SHALL abort immediately; any im_we pulse SHALL be cancelled, and already-written memory words are not erased.

Verification
REQ-030 The bench SHALL apply bytes 00 02 12 34 AB CD 40 (XOR = 0x40) and check:
- writes (0, 0x1234) then (1, 0xABCD);
- word_count = 2;
- load_done = 1, core_rst_n = 1, rx_ready = 0.
REQ-031 The bench SHALL apply the same stream with checksum 0x41 and check: load_err = 1, core_rst_n = 0, load_done = 0, word_count = 2; further bytes are ignored.
REQ-032 The bench SHALL apply bytes 01 01 with IM_DEPTH = 256 and check: S_ERR after the second byte, and no im_we ever asserted.
REQ-033 The bench SHALL apply bytes 00 00 00 and check: load_done = 1, and no im_we ever asserted.
REQ-034 The bench SHALL apply rx_valid gaps at random between bytes and check that the results are identical to REQ-030.
REQ-035 The bench SHALL apply rst = 0 after byte 5 of REQ-030, then resend the full stream, and check:
- after reset, word_count = 0 and core_rst_n = 0;
- the reload completes as in REQ-030.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte
// stream and writes it into instruction memory. The core is released from
// reset only after the checksum over the data bytes matches.
module program_loader #(
  parameter int IM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // Compare the 16-bit length with one spare bit so IM_DEPTH = 65536 still works.
  localparam logic [16:0] DEPTH_L = 17'(IM_DEPTH);

  state_t      state;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [7:0]  run_xor;
  logic [15:0] len;
  logic        acc;
  logic [15:0] len_rx;
  logic [15:0] wc_next;

  assign acc     = rx_valid & rx_ready;
  assign len_rx  = {len_hi, rx_data};
  assign wc_next = word_count + 16'd1;

  // Byte holding registers: only ever read after being written in the same
  // load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (acc && state == S_LEN_HI) len_hi  <= rx_data;
    if (acc && state == S_DATA_HI) data_hi <= rx_data;
  end

  // Loader FSM with registered handshake, memory-write and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LEN_HI;
      rx_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= 16'd0;
      im_wdata   <= 16'd0;
      word_count <= 16'd0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      run_xor    <= 8'd0;
      len        <= 16'd0;
    end else begin
      // Write strobe is a single-cycle pulse following each low data byte.
      im_we <= 1'b0;
      case (state)
        S_LEN_HI: begin
          rx_ready <= 1'b1;
          if (acc) state <= S_LEN_LO;
        end

        S_LEN_LO: begin
          rx_ready <= 1'b1;
          if (acc) begin
            len <= len_rx;
            if ({1'b0, len_rx} > DEPTH_L) begin
              state    <= S_ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (len_rx == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end

        S_DATA_HI: begin
          rx_ready <= 1'b1;
          if (acc) begin
            run_xor <= run_xor ^ rx_data;
            state   <= S_DATA_LO;
          end
        end

        S_DATA_LO: begin
          rx_ready <= 1'b1;
          if (acc) begin
            run_xor    <= run_xor ^ rx_data;
            im_we      <= 1'b1;
            im_addr    <= word_count;
            im_wdata   <= {data_hi, rx_data};
            word_count <= wc_next;
            state      <= (wc_next == len) ? S_CHECK : S_DATA_HI;
          end
        end

        S_CHECK: begin
          rx_ready <= 1'b1;
          if (acc) begin
            rx_ready <= 1'b0;
            if (rx_data == run_xor) begin
              state      <= S_DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end

        S_DONE: rx_ready <= 1'b0;

        S_ERR: rx_ready <= 1'b0;

        default: begin
          rx_ready <= 1'b0;
          load_err <= 1'b1;
          state    <= S_ERR;
        end
      endcase
    end
  end

endmodule
